// File: rtl/rotary_ctrl.sv
// rotary_ctrl: front-panel rotary encoder controller.
// Samples A/B/switch on a prescaled tick, debounces each input, decodes full
// quadrature detents into CW/CCW events, and keeps a bounded value register.
// Events leave through a single-entry valid/ready port with a sticky overflow flag.
// Optional build macro: ROTARY_CTRL_SYNC_EN adds 2-flop input synchronizers.
module rotary_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SAMPLE_DIV  = 1000,
  parameter int DEB_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_sw,
  input  logic [WIDTH-1:0] cfg_min,
  input  logic [WIDTH-1:0] cfg_max,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic             cfg_wrap,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_load_val,
  output logic [WIDTH-1:0] value,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic             evt_ovf
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int RW = $clog2(DEB_SAMPLES + 1);

  // State encoding equals the stable {A,B} level it represents.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } qstate_t;

  logic [2:0] raw;  // {a, b, sw}

`ifdef ROTARY_CTRL_SYNC_EN
  logic [2:0] sync1, sync2;

  // Two-stage synchronizer for the asynchronous panel inputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 3'b110;
      sync2 <= 3'b110;
    end else begin
      sync1 <= {enc_a, enc_b, enc_sw};
      sync2 <= sync1;
    end
  end
  assign raw = sync2;
`else
  assign raw = {enc_a, enc_b, enc_sw};
`endif

  logic [PW-1:0] pcnt;
  logic          tick;
  logic [2:0]    cand, cand_n, stab, stab_n;
  logic [RW-1:0] run   [3];
  logic [RW-1:0] run_n [3];
  qstate_t       qs;
  logic [2:0]    sub;
  logic [3:0]    sub_nx;
  logic [1:0]    ab_n, cw_ab, ccw_ab;
  logic          step_cw, step_ccw, jump;
  logic          det_cw, det_ccw, sw_rise, sw_fall;
  logic [WIDTH:0]   v_inc, min_step;
  logic [WIDTH-1:0] cw_val, ccw_val, load_clamped;
  logic             cfg_bad;
  logic             new_evt, sw_drop, can_load;
  logic [1:0]       new_code;

  assign tick = (pcnt == PW'(SAMPLE_DIV - 1));

  // Debounce: per-input candidate level and saturating run length on each tick.
  always_comb begin
    cand_n = cand;
    stab_n = stab;
    for (int unsigned i = 0; i < 3; i++) begin
      run_n[i] = run[i];
      if (tick) begin
        if (raw[i] == cand[i]) begin
          if (run[i] != RW'(DEB_SAMPLES)) run_n[i] = run[i] + RW'(1);
        end else begin
          cand_n[i] = raw[i];
          run_n[i]  = RW'(1);
        end
        if (run_n[i] == RW'(DEB_SAMPLES)) stab_n[i] = cand_n[i];
      end
    end
  end

  // Quadrature step classification against the new stable level.
  always_comb begin
    ab_n = stab_n[2:1];
    case (qs)
      S11:     begin cw_ab = 2'b01; ccw_ab = 2'b10; end
      S01:     begin cw_ab = 2'b00; ccw_ab = 2'b11; end
      S00:     begin cw_ab = 2'b10; ccw_ab = 2'b01; end
      default: begin cw_ab = 2'b11; ccw_ab = 2'b00; end
    endcase
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    jump     = 1'b0;
    if (ab_n != 2'(qs)) begin
      if (ab_n == cw_ab)       step_cw  = 1'b1;
      else if (ab_n == ccw_ab) step_ccw = 1'b1;
      else                     jump     = 1'b1;
    end
    // Sub-count is evaluated one bit wider so that +4/-4 are distinguishable.
    sub_nx  = {sub[2], sub} + (step_cw ? 4'b0001 : (step_ccw ? 4'b1111 : 4'b0000));
    det_cw  = step_cw  && (ab_n == 2'b11) && (sub_nx == 4'b0100);
    det_ccw = step_ccw && (ab_n == 2'b11) && (sub_nx == 4'b1100);
    sw_rise = stab_n[0] & ~stab[0];
    sw_fall = ~stab_n[0] & stab[0];
  end

  // Bounded value arithmetic and event selection.
  always_comb begin
    v_inc    = {1'b0, value} + {1'b0, cfg_step};
    min_step = {1'b0, cfg_min} + {1'b0, cfg_step};
    if (v_inc > {1'b0, cfg_max}) cw_val = cfg_wrap ? cfg_min : cfg_max;
    else                         cw_val = v_inc[WIDTH-1:0];
    if ({1'b0, value} < min_step) ccw_val = cfg_wrap ? cfg_max : cfg_min;
    else                          ccw_val = value - cfg_step;
    if (cfg_load_val < cfg_min)      load_clamped = cfg_min;
    else if (cfg_load_val > cfg_max) load_clamped = cfg_max;
    else                             load_clamped = cfg_load_val;
    cfg_bad  = cfg_min > cfg_max;
    new_evt  = det_cw | det_ccw | sw_rise | sw_fall;
    sw_drop  = (det_cw | det_ccw) & (sw_rise | sw_fall);
    if (det_cw)       new_code = 2'b00;
    else if (det_ccw) new_code = 2'b01;
    else if (sw_rise) new_code = 2'b10;
    else              new_code = 2'b11;
    can_load = ~evt_valid | evt_ready;
  end

  // Prescaler, debounce state, quadrature FSM, value and event registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcnt      <= '0;
      cand      <= 3'b110;
      stab      <= 3'b110;
      for (int unsigned i = 0; i < 3; i++) run[i] <= '0;
      qs        <= S11;
      sub       <= '0;
      value     <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 2'b00;
      evt_ovf   <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      cand <= cand_n;
      stab <= stab_n;
      for (int unsigned i = 0; i < 3; i++) run[i] <= run_n[i];

      if (jump) begin
        qs  <= qstate_t'(ab_n);
        sub <= '0;
      end else if (step_cw || step_ccw) begin
        qs  <= qstate_t'(ab_n);
        sub <= (ab_n == 2'b11) ? 3'b000 : sub_nx[2:0];
      end

      if (cfg_load)                 value <= load_clamped;
      else if (det_cw && !cfg_bad)  value <= cw_val;
      else if (det_ccw && !cfg_bad) value <= ccw_val;

      if (new_evt && can_load) begin
        evt_valid <= 1'b1;
        evt_code  <= new_code;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (cfg_load)                               evt_ovf <= 1'b0;
      else if (sw_drop || (new_evt && !can_load)) evt_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rotary_ctrl.sv
// tb_rotary_ctrl: directed test-plan scenarios plus randomized encoder/config
// activity, checked every cycle against a tick-level behavioural model.
module tb_rotary_ctrl;

  localparam int WIDTH = 8;
  localparam int SDIV  = 4;
  localparam int DEB   = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             enc_a, enc_b, enc_sw;
  logic [WIDTH-1:0] cfg_min, cfg_max, cfg_step, cfg_load_val;
  logic             cfg_wrap, cfg_load;
  logic [WIDTH-1:0] value;
  logic             evt_valid, evt_ready, evt_ovf;
  logic [1:0]       evt_code;

  rotary_ctrl #(.WIDTH(WIDTH), .SAMPLE_DIV(SDIV), .DEB_SAMPLES(DEB)) dut (
    .clk(clk), .rstn(rstn), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step), .cfg_wrap(cfg_wrap),
    .cfg_load(cfg_load), .cfg_load_val(cfg_load_val), .value(value),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (tick granularity) ----------------
  bit m_init = 0;
  int m_cyc, m_nsamp, m_pos, m_sub, m_val, m_valid, m_code, m_ovf;
  int m_st   [3];
  int m_hist [3][DEB];
  int m_in   [3];
  int m_old  [3];
  int m_s1   [3];
  int m_s2   [3];
  int pn, dlt, det, swe, newc;
  bit tk, acc, drop, eq;

  function automatic int pos_of(input int a, input int b);
    if (a == 1 && b == 1) return 0;
    if (a == 0 && b == 1) return 1;
    if (a == 0 && b == 0) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_init = 1; m_cyc = 0; m_nsamp = 0; m_pos = 0; m_sub = 0;
      m_val = 0; m_valid = 0; m_code = 0; m_ovf = 0;
      m_st[0] = 1; m_st[1] = 1; m_st[2] = 0;
      m_s1 = m_st; m_s2 = m_st;
    end else begin
`ifdef ROTARY_CTRL_SYNC_EN
      m_in = m_s2; m_s2 = m_s1;
      m_s1[0] = int'(enc_a); m_s1[1] = int'(enc_b); m_s1[2] = int'(enc_sw);
`else
      m_in[0] = int'(enc_a); m_in[1] = int'(enc_b); m_in[2] = int'(enc_sw);
`endif
      tk = (m_cyc % SDIV) == SDIV - 1;
      m_cyc++;
      det = 0; swe = 0;
      m_old = m_st;
      if (tk) begin
        m_nsamp++;
        for (int i = 0; i < 3; i++) begin
          for (int k = DEB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
          m_hist[i][0] = m_in[i];
          if (m_nsamp >= DEB) begin
            eq = 1;
            for (int k = 1; k < DEB; k++) if (m_hist[i][k] != m_hist[i][0]) eq = 0;
            if (eq) m_st[i] = m_hist[i][0];
          end
        end
      end
      if (m_st[0] != m_old[0] || m_st[1] != m_old[1]) begin
        pn  = pos_of(m_st[0], m_st[1]);
        dlt = (pn - m_pos + 4) % 4;
        if (dlt == 2) m_sub = 0;
        else begin
          m_sub += (dlt == 1) ? 1 : -1;
          if (pn == 0) begin
            if (m_sub == 4) det = 1;
            else if (m_sub == -4) det = 2;
            m_sub = 0;
          end
        end
        m_pos = pn;
      end
      if (m_st[2] != m_old[2]) swe = m_st[2] ? 2 : 3;

      if (cfg_load) begin
        if (cfg_load_val < cfg_min) m_val = cfg_min;
        else if (cfg_load_val > cfg_max) m_val = cfg_max;
        else m_val = cfg_load_val;
      end else if (det != 0 && cfg_min <= cfg_max) begin
        if (det == 1) begin
          m_val = m_val + cfg_step;
          if (m_val > cfg_max) m_val = cfg_wrap ? cfg_min : cfg_max;
        end else begin
          if (m_val < cfg_min + cfg_step) m_val = cfg_wrap ? cfg_max : cfg_min;
          else m_val = m_val - cfg_step;
        end
      end

      acc  = (m_valid == 1) && evt_ready;
      drop = (det != 0) && (swe != 0);
      newc = (det == 1) ? 0 : (det == 2) ? 1 : swe;
      if (det != 0 || swe != 0) begin
        if (m_valid == 0 || acc) begin m_valid = 1; m_code = newc; end
        else drop = 1;
      end else if (acc) m_valid = 0;
      if (cfg_load) m_ovf = 0;
      else if (drop) m_ovf = 1;
    end
  end

  int acc_q[$];

  // Per-cycle comparison against the model, plus a log of accepted event codes.
  always @(negedge clk) begin
    if (m_init) begin
      check_eq("value", value, m_val);
      check_eq("evt_valid", evt_valid, m_valid);
      check_eq("evt_ovf", evt_ovf, m_ovf);
      if (m_valid == 1) check_eq("evt_code", evt_code, m_code);
    end
    if (evt_valid && evt_ready) acc_q.push_back(int'(evt_code));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic move(input int a, input int b, input int n);
    enc_a = a[0]; enc_b = b[0];
    cyc_wait(n);
  endtask

  task automatic cw_detent();
    move(0, 1, 12); move(0, 0, 12); move(1, 0, 12); move(1, 1, 12);
  endtask

  task automatic ccw_detent();
    move(1, 0, 12); move(0, 0, 12); move(0, 1, 12); move(1, 1, 12);
  endtask

  task automatic do_load(input int v);
    cfg_load_val = v[WIDTH-1:0];
    cfg_load = 1'b1;
    cyc_wait(1);
    cfg_load = 1'b0;
  endtask

  task automatic pulse_ready();
    evt_ready = 1'b1;
    cyc_wait(1);
    evt_ready = 1'b0;
  endtask

  int nacc, rp, r;

  initial begin
    rstn = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b0;
    cfg_min = 8'd0; cfg_max = 8'd20; cfg_step = 8'd3; cfg_wrap = 1'b0;
    cfg_load = 1'b0; cfg_load_val = '0; evt_ready = 1'b0;
    cyc_wait(3);
    rstn = 1'b1;

    // Idle after reset
    cyc_wait(100);
    check_eq("idle_value", value, 0);
    check_eq("idle_valid", evt_valid, 0);
    check_eq("idle_ovf", evt_ovf, 0);
    check_eq("idle_code", evt_code, 0);

    // Load then one CW detent, held then accepted
    do_load(10);
    cw_detent();
    check_eq("cw_value", value, 13);
    check_eq("cw_valid", evt_valid, 1);
    check_eq("cw_code", evt_code, 0);
    cyc_wait(20);
    check_eq("cw_hold_valid", evt_valid, 1);
    pulse_ready();
    check_eq("cw_accepted", evt_valid, 0);

    // Saturation, wrap high, wrap low
    do_load(19); cw_detent();
    check_eq("sat_value", value, 20);
    pulse_ready();
    cfg_wrap = 1'b1;
    do_load(19); cw_detent();
    check_eq("wrap_hi_value", value, 0);
    pulse_ready();
    do_load(1); ccw_detent();
    check_eq("wrap_lo_value", value, 20);
    check_eq("ccw_code", evt_code, 1);
    pulse_ready();

    // Single-tick bounce and invalid jump: no events, value kept
    evt_ready = 1'b1;
    nacc = acc_q.size();
    move(0, 1, 4); move(1, 1, 12);
    move(0, 0, 12); move(1, 1, 12);
    check_eq("glitch_events", acc_q.size() - nacc, 0);
    check_eq("glitch_value", value, 20);

    // Overflow with consumer stalled, cleared by load
    evt_ready = 1'b0; cfg_wrap = 1'b0;
    do_load(0);
    cw_detent(); cw_detent();
    check_eq("ovf_value", value, 6);
    check_eq("ovf_valid", evt_valid, 1);
    check_eq("ovf_code", evt_code, 0);
    check_eq("ovf_flag", evt_ovf, 1);
    do_load(5);
    check_eq("ovf_cleared", evt_ovf, 0);
    check_eq("ovf_load_value", value, 5);
    evt_ready = 1'b1;
    cyc_wait(2);

    // Switch press then release
    acc_q.delete();
    enc_sw = 1'b1; cyc_wait(12);
    enc_sw = 1'b0; cyc_wait(12);
    check_eq("sw_events", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check_eq("sw_press", acc_q[0], 2);
      check_eq("sw_release", acc_q[1], 3);
    end

    // Reset in the middle of a CW sequence
    evt_ready = 1'b0;
    enc_sw = 1'b1; cyc_wait(12);
    move(0, 1, 12); move(0, 0, 12);
    rstn = 1'b0;
    cyc_wait(1);
    check_eq("rst_value", value, 0);
    check_eq("rst_valid", evt_valid, 0);
    check_eq("rst_ovf", evt_ovf, 0);
    check_eq("rst_code", evt_code, 0);
    rstn = 1'b1; enc_sw = 1'b0;
    move(1, 0, 12); move(1, 1, 40);

    // Randomized activity, checked by the per-cycle model comparison
    rp = 0;
    for (int it = 0; it < 500; it++) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        if (cfg_min <= cfg_max) do_load($urandom_range(0, 255));
      end else if (r == 1) begin
        cfg_min  = $urandom_range(0, 60);
        cfg_max  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'(cfg_min + $urandom_range(0, 150));
        cfg_step = $urandom_range(0, 40);
        cfg_wrap = $urandom_range(0, 1);
      end else if (r == 2) begin
        enc_sw = ~enc_sw;
        cyc_wait($urandom_range(1, 14));
      end else if (r == 3) begin
        move($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 14));
      end else begin
        rp = (r < 10) ? (rp + 1) % 4 : (rp + 3) % 4;
        case (rp)
          0: move(1, 1, $urandom_range(1, 14));
          1: move(0, 1, $urandom_range(1, 14));
          2: move(0, 0, $urandom_range(1, 14));
          default: move(1, 0, $urandom_range(1, 14));
        endcase
      end
    end
    cyc_wait(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rotary_ctrl.md
# rotary_ctrl

Controller for the front-panel rotational encoder: samples the quadrature (A/B) and push-switch inputs at a programmable rate, debounces them, decodes full detents, and maintains a bounded, configurable value register. Detent and switch events go to the downstream consumer (menu/UI logic) through a single-entry valid/ready event port. The block sits between the encoder pins and the system control logic.

## Interface

Parameters:
- WIDTH, 8, width of value and configuration words
- SAMPLE_DIV, 1000, clk cycles per sample tick (>= 2)
- DEB_SAMPLES, 4, consecutive equal samples required to accept an input level (>= 1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  synchronous, active-low reset
- enc_a  input  1  encoder channel A (idle high)
- enc_b  input  1  encoder channel B (idle high)
- enc_sw  input  1  encoder push switch, 1 = pressed
- cfg_min  input  WIDTH  lower bound of value (unsigned)
- cfg_max  input  WIDTH  upper bound of value (unsigned)
- cfg_step  input  WIDTH  increment per detent
- cfg_wrap  input  1  1 = wrap at bounds, 0 = saturate
- cfg_load  input  1  one-cycle strobe: load cfg_load_val into value
- cfg_load_val  input  WIDTH  value to load
- value  output  WIDTH  current value register
- evt_valid  output  1  event pending
- evt_ready  input  1  consumer accepts event
- evt_code  output  2  00 CW detent, 01 CCW detent, 10 press, 11 release
- evt_ovf  output  1  sticky: an event was dropped

## Operation

- Prescaler counts 0..SAMPLE_DIV-1; `tick` asserted for one cycle when count = SAMPLE_DIV-1, then wraps to 0.
- Debounce, per input, on tick only: sample equal to candidate -> run count +1 (saturating), else candidate = sample, run = 1. When run reaches DEB_SAMPLES, stable level = candidate.
- Quadrature FSM on stable {A,B}; states S11 (detent), S01, S00, S10. CW sequence 11->01->00->10->11, CCW the reverse. Signed sub-count (3 bits): +1 per CW quarter step, -1 per CCW quarter step. A jump changing both bits is invalid: state resyncs to the new input, sub-count cleared, no event. On entry to S11: sub = +4 -> CW detent; sub = -4 -> CCW detent; sub then cleared.
- Value arithmetic in WIDTH+1 bits. CW: v = value + cfg_step; if v > cfg_max, then cfg_wrap ? cfg_min : cfg_max. CCW: if value < cfg_min + cfg_step, then cfg_wrap ? cfg_max : cfg_min, else value - cfg_step.
- cfg_min > cfg_max: rotation leaves value unchanged (events still emitted).
- cfg_load: value = cfg_load_val clamped to [cfg_min, cfg_max]. Load wins over a same-cycle detent update; the detent event is still emitted.
- Switch: rising edge of stable sw -> press event, falling edge -> release event.
- Event register: loaded when empty or being accepted this cycle (evt_valid & evt_ready). Otherwise the new event is dropped and evt_ovf is set. Detent and switch event on the same tick: detent is taken, switch event is dropped and evt_ovf is set.
- evt_ovf is cleared only by reset or cfg_load.

## Timing

- Reset values: value = 0, evt_valid = 0, evt_code = 00, evt_ovf = 0. Stable A/B = 1, FSM = S11, sub = 0, stable sw = 0, prescaler = 0, debounce run counts = 0.
- Input level accepted on the DEB_SAMPLES-th consecutive tick seeing it.
- value and evt_valid/evt_code update on the clk edge following the tick that completes a detent or switch edge (1-cycle latency).
- evt_valid stays high and evt_code stays stable until accepted; both deassert or reload on the edge after acceptance.
- cfg_load takes effect on the next edge.
- Reset asserted mid-sequence returns the block to reset values on the next edge; no partial detent survives.

## Configuration

- ROTARY_CTRL_SYNC_EN defined: enc_a, enc_b and enc_sw each pass through a 2-flop synchronizer (reset value 1, 1, 0) before sampling. This adds 2 clk of latency.
- Undefined: the inputs are sampled directly and must already be synchronous to clk.

## Test plan

All scenarios use SAMPLE_DIV=4, DEB_SAMPLES=2, WIDTH=8.

- Reset, then idle 100 cycles -> value=0, evt_valid=0, evt_ovf=0.
- Load 10 with min=0, max=20, step=3, then one clean CW detent -> value=13, evt_code=00. Hold evt_ready=0 -> evt_valid stays 1; pulse ready -> evt_valid=0.
- Saturation and wrap: value=19, max=20, step=3, CW with cfg_wrap=0 -> 20. Same start with cfg_wrap=1 -> 0 (min). Value=1, min=0, CCW with wrap=1 -> 20.
- Bounce: toggle A for a single tick inside a quarter step -> no state change, no event. Invalid 11->00 jump -> no event, value unchanged.
- Overflow: two CW detents with evt_ready=0 -> first event held, evt_ovf=1, value advanced twice. Then cfg_load -> evt_ovf=0.
- Switch: press held 3 ticks, then release -> press event (10), then release event (11). Rstn asserted mid-CW-sequence -> all outputs at reset values next cycle.
